// File: rtl/mss_tone_pkg.sv
// Shared types and default widths for the MSS sine-table sound path.
// The width localparams are also used to size the sine-table instance.
package mss_tone_pkg;

  localparam int TONE_COUNT_SIZE = 8;
  localparam int TONE_ACC_W      = 16;
  localparam int TONE_DUR_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DRAIN
  } tone_state_t;

endpackage

// File: rtl/tone_phase_gen.sv
// Phase-accumulator NCO that drives the sine-table address, one step per sample tick.
// Each tone ends exactly at a phase wrap, so the output stops at sine = 0.
module tone_phase_gen
  import mss_tone_pkg::*;
#(
  parameter int COUNT_SIZE = TONE_COUNT_SIZE,
  parameter int ACC_W      = TONE_ACC_W,
  parameter int DUR_W      = TONE_DUR_W
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  sample_tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ACC_W-1:0]      phase_inc,
  input  logic [DUR_W-1:0]      duration,
  output logic [COUNT_SIZE-1:0] ADDR,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  done
);

  tone_state_t      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             step_q, step_d;
  logic             valid_q;
  logic             done_q, done_d;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, inc_q};

  // NOTE: every signal gets its default first, so no path through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    inc_d   = inc_q;
    dur_d   = dur_q;
    step_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        acc_d = '0;
        if (start) begin
          inc_d = phase_inc;
          dur_d = duration;
          if (duration == '0 || phase_inc == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = PLAY;
          end
        end
      end

      PLAY: begin
        if (sample_tick) begin
          acc_d  = sum[ACC_W-1:0];
          dur_d  = dur_q - DUR_W'(1);
          step_d = 1'b1;
          if (dur_q == DUR_W'(1)) begin
            state_d = DRAIN;
          end
        end
        if (stop) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (sample_tick) begin
          step_d = 1'b1;
          // A carry means the phase just passed 2^ACC_W: park exactly on 0, not on the wrapped residue.
          if (sum[ACC_W]) begin
            acc_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      acc_q   <= '0;
      inc_q   <= '0;
      dur_q   <= '0;
      step_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      dur_q   <= dur_d;
      step_q  <= step_d;
      valid_q <= step_q;
      done_q  <= done_d;
    end
  end

  // valid trails the address by one clock to line up with the sine table's registered Q.
  assign ADDR         = acc_q[ACC_W-1 -: COUNT_SIZE];
  assign sample_valid = valid_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_tone_phase_gen.sv
// Scoreboard bench for tone_phase_gen: each stepping tick queues its expected
// address and the cycle its sample_valid must appear on.
module tb_tone_phase_gen;

  logic        clk = 1'b0;
  logic        resetN;
  logic        sample_tick;
  logic        start;
  logic        stop;
  logic [15:0] phase_inc;
  logic [15:0] duration;
  logic [7:0]  ADDR;
  logic        sample_valid;
  logic        busy;
  logic        done;

  typedef struct {
    logic [7:0]  addr;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  int          valid_cnt = 0;
  int          busy_cnt = 0;
  logic [7:0]  addr_prev = '0;

  tone_phase_gen dut (
    .clk          (clk),
    .resetN       (resetN),
    .sample_tick  (sample_tick),
    .start        (start),
    .stop         (stop),
    .phase_inc    (phase_inc),
    .duration     (duration),
    .ADDR         (ADDR),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // addr_prev models the sine table's registered address, so on sample_valid
  // it holds the address whose sample is now on the table output.
  always @(negedge clk) begin
    if (resetN) begin
      if (busy) busy_cnt <= busy_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (sample_valid) begin
        valid_cnt <= valid_cnt + 1;
        if (sb_q.size() == 0) begin
          check("spurious_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("valid_addr", {24'd0, addr_prev}, {24'd0, e.addr});
          check("valid_cyc", cyc, e.cyc);
        end
      end
    end
    addr_prev <= ADDR;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [15:0] inc, input logic [15:0] dur, input logic with_tick);
    start       = 1'b1;
    phase_inc   = inc;
    duration    = dur;
    sample_tick = with_tick;
    @(posedge clk);
    #1;
    start       = 1'b0;
    sample_tick = 1'b0;
  endtask

  task automatic tick(input logic [7:0] exp, input bit steps, input bit stp);
    sample_tick = 1'b1;
    stop        = stp;
    if (steps) sb_q.push_back('{addr: exp, cyc: cyc + 2});
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    stop        = 1'b0;
    if (steps) check("addr_now", {24'd0, ADDR}, {24'd0, exp});
  endtask

  task automatic end_of_tone(input string tag, input int done_base, input int valid_base, input int n_valid);
    idle(4);
    check({tag, "_sb_empty"}, sb_q.size(), 32'd0);
    check({tag, "_done_cnt"}, done_cnt - done_base, 32'd1);
    check({tag, "_valid_cnt"}, valid_cnt - valid_base, n_valid);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, "_addr_end"}, {24'd0, ADDR}, 32'd0);
  endtask

  task automatic quarter_tone(input string tag, input int gap);
    int db, vb;
    db = done_cnt;
    vb = valid_cnt;
    do_start(16'h4000, 16'd2, 1'b0);
    tick(8'h40, 1, 0); idle(gap);
    tick(8'h80, 1, 0); idle(gap);
    tick(8'hC0, 1, 0); idle(gap);
    tick(8'h00, 1, 0); idle(gap);
    end_of_tone(tag, db, vb, 4);
  endtask

  initial begin
    int db, vb;
    resetN      = 1'b0;
    sample_tick = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    phase_inc   = '0;
    duration    = '0;
    #2;
    check("rst_addr", {24'd0, ADDR}, 32'd0);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    idle(2);
    resetN = 1'b1;
    idle(2);

    // 1: quarter-turn steps, a tick every 4 clocks
    quarter_tone("t1", 3);

    // 2: back-to-back ticks; busy covers exactly four clocks
    db = done_cnt;
    vb = valid_cnt;
    busy_cnt = 0;
    do_start(16'h4000, 16'd2, 1'b0);
    tick(8'h40, 1, 0);
    tick(8'h80, 1, 0);
    tick(8'hC0, 1, 0);
    tick(8'h00, 1, 0);
    end_of_tone("t2", db, vb, 4);
    check("t2_busy_clks", busy_cnt, 32'd4);

    // 3: early stop on the 10th tick, then drain to the wrap
    db = done_cnt;
    vb = valid_cnt;
    do_start(16'h0100, 16'd1000, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      tick(8'(i), 1, i == 10);
      idle(1);
    end
    for (int a = 11; a <= 255; a++) begin
      tick(8'(a), 1, 0);
      idle(1);
    end
    tick(8'h00, 1, 0);
    end_of_tone("t3", db, vb, 256);

    // 4: zero duration and zero increment finish at once without stepping
    vb = valid_cnt;
    busy_cnt = 0;
    do_start(16'h4000, 16'd0, 1'b0);
    check("t4_dur0_done", {31'd0, done}, 32'd1);
    idle(1);
    check("t4_done_width", {31'd0, done}, 32'd0);
    do_start(16'h0000, 16'd5, 1'b0);
    check("t4_inc0_done", {31'd0, done}, 32'd1);
    tick(8'h00, 0, 0);
    tick(8'h00, 0, 0);
    idle(3);
    check("t4_addr", {24'd0, ADDR}, 32'd0);
    check("t4_no_valid", valid_cnt - vb, 32'd0);
    check("t4_no_busy", busy_cnt, 32'd0);

    // 5: tick with start is not a step; a retrigger while busy is ignored
    db = done_cnt;
    vb = valid_cnt;
    do_start(16'h4000, 16'd2, 1'b1);
    check("t5_no_step", {24'd0, ADDR}, 32'd0);
    tick(8'h40, 1, 0); idle(1);
    do_start(16'h1000, 16'd50, 1'b0);
    tick(8'h80, 1, 0); idle(1);
    tick(8'hC0, 1, 0); idle(1);
    tick(8'h00, 1, 0); idle(1);
    end_of_tone("t5", db, vb, 4);

    // 6: asynchronous reset mid-tone clears at once, then a clean restart
    db = done_cnt;
    do_start(16'h4000, 16'd100, 1'b0);
    tick(8'h40, 1, 0);
    tick(8'h80, 1, 0);
    #2;
    resetN = 1'b0;
    #1;
    check("t6_rst_addr", {24'd0, ADDR}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_valid", {31'd0, sample_valid}, 32'd0);
    sb_q.delete();
    idle(2);
    resetN = 1'b1;
    idle(2);
    check("t6_no_done", done_cnt - db, 32'd0);
    quarter_tone("t6_restart", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
